// File: rtl/paddle_controller.sv
// paddle_controller: turns two raw push-buttons into a clamped paddle position and
// a column mask. Each button is synchronised and debounced. A press moves the paddle
// one column, and holding the button repeats the move. Pressing both buttons
// freezes the paddle until both are released.
module paddle_controller #(
    parameter int COL             = 4,
    parameter int PADDLE_W        = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_left,
    input  logic                   btn_right,
    output logic [COL-1:0]         down_player,
    output logic [$clog2(COL)-1:0] paddle_pos,
    output logic                   moved
);

    localparam int PW  = $clog2(COL);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPW = $clog2(REPEAT_CYCLES);

    localparam logic [PW-1:0]  POS_MAX   = PW'(COL - PADDLE_W);
    localparam logic [PW-1:0]  POS_RST   = PW'((COL - PADDLE_W) / 2);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPW-1:0] REP_LAST  = RPW'(REPEAT_CYCLES - 1);
    localparam logic [COL-1:0] MASK_BASE = COL'((1 << PADDLE_W) - 1);
    localparam logic [COL-1:0] MASK_RST  = MASK_BASE << POS_RST;

    typedef enum logic [1:0] {
        StIdle,
        StHoldL,
        StHoldR,
        StBoth
    } state_t;

    // Bit 0 carries the left button, bit 1 the right button.
    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [1:0][DBW-1:0] r_cnt;
    logic [1:0][DBW-1:0] w_cnt_next;
    logic [1:0]          r_db;
    logic [1:0]          w_db_next;

    state_t              r_state;
    state_t              w_state_next;
    logic [RPW-1:0]      r_rep;
    logic [RPW-1:0]      w_rep_next;
    logic                w_step_l;
    logic                w_step_r;
    logic                w_dl;
    logic                w_dr;

    logic [PW-1:0]       r_pos;
    logic [PW-1:0]       w_pos_next;
    logic [COL-1:0]      r_mask;
    logic [COL-1:0]      w_mask_next;
    logic                r_moved;
    logic                w_moved_next;

    assign w_dl = r_db[0];
    assign w_dr = r_db[1];

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_right, btn_left};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state. The level flips only after DEBOUNCE_CYCLES disagreeing samples in a row.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_db_next[i]  = r_db[i];
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_db[i]) begin
                if (r_cnt[i] == DB_LAST) begin
                    w_db_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_db  <= w_db_next;
        end
    end

    // Button FSM: next state, repeat counter and step requests.
    always_comb begin
        w_state_next = r_state;
        w_rep_next   = r_rep;
        w_step_l     = 1'b0;
        w_step_r     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_dl && !w_dr) begin
                    w_step_l     = 1'b1;
                    w_rep_next   = '0;
                    w_state_next = StHoldL;
                end else if (w_dr && !w_dl) begin
                    w_step_r     = 1'b1;
                    w_rep_next   = '0;
                    w_state_next = StHoldR;
                end else if (w_dl && w_dr) begin
                    w_state_next = StBoth;
                end
            end
            StHoldL: begin
                // The opposite button takes priority so that a chord never moves the paddle.
                if (w_dr) begin
                    w_state_next = StBoth;
                end else if (!w_dl) begin
                    w_state_next = StIdle;
                end else if (r_rep == REP_LAST) begin
                    w_step_l   = 1'b1;
                    w_rep_next = '0;
                end else begin
                    w_rep_next = r_rep + 1'b1;
                end
            end
            StHoldR: begin
                if (w_dl) begin
                    w_state_next = StBoth;
                end else if (!w_dr) begin
                    w_state_next = StIdle;
                end else if (r_rep == REP_LAST) begin
                    w_step_r   = 1'b1;
                    w_rep_next = '0;
                end else begin
                    w_rep_next = r_rep + 1'b1;
                end
            end
            StBoth: begin
                // Only a full release returns to idle; a partial release must not start a hold.
                if (!w_dl && !w_dr) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM state and repeat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_rep   <= '0;
        end else begin
            r_state <= w_state_next;
            r_rep   <= w_rep_next;
        end
    end

    // Clamped step. A step into the edge leaves the position unchanged and raises no pulse.
    always_comb begin
        w_pos_next = r_pos;
        if (w_step_l && (r_pos != '0)) begin
            w_pos_next = r_pos - 1'b1;
        end else if (w_step_r && (r_pos < POS_MAX)) begin
            w_pos_next = r_pos + 1'b1;
        end
        w_moved_next = (w_pos_next != r_pos);
        w_mask_next  = MASK_BASE << w_pos_next;
    end

    // Output registers. The mask is registered with the position so the two always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos   <= POS_RST;
            r_mask  <= MASK_RST;
            r_moved <= 1'b0;
        end else begin
            r_pos   <= w_pos_next;
            r_mask  <= w_mask_next;
            r_moved <= w_moved_next;
        end
    end

    assign paddle_pos  = r_pos;
    assign down_player = r_mask;
    assign moved       = r_moved;

endmodule

// File: tb/tb_paddle_controller.sv
// Testbench for paddle_controller: directed scenarios plus randomized button traffic.
// A behavioural model of the button rules is compared with the DUT on every cycle.
module tb_paddle_controller;

    localparam int COL  = 4;
    localparam int PWD  = 2;
    localparam int DB   = 4;
    localparam int REP  = 8;
    localparam int POSW = $clog2(COL);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            btn_left = 1'b0;
    logic            btn_right = 1'b0;
    logic [COL-1:0]  down_player;
    logic [POSW-1:0] paddle_pos;
    logic            moved;

    int checks = 0;
    int failures = 0;

    paddle_controller #(
        .COL             (COL),
        .PADDLE_W        (PWD),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .down_player (down_player),
        .paddle_pos  (paddle_pos),
        .moved       (moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_win holds the most recent synchronised samples. A level flips once DB of them in a row
    // disagree with it. Stepping time is measured as edges since the first step of a hold.
    int m_s1[2];
    int m_s[2];
    int m_db[2];
    int m_win[2][$];
    int m_mode;    // 0 idle, 1 left held, 2 right held, 3 both
    int m_edge;
    int m_t0;
    int m_pos;
    int m_moved;

    function automatic int exp_mask(input int p);
        return ((1 << PWD) - 1) << p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0;
            m_s[i]  = 0;
            m_db[i] = 0;
            m_win[i].delete();
        end
        m_mode  = 0;
        m_edge  = 0;
        m_t0    = 0;
        m_pos   = (COL - PWD) / 2;
        m_moved = 0;
    endtask

    task automatic model_step(input int raw_l, input int raw_r);
        int dl;
        int dr;
        int dir;
        int np;
        int all_diff;
        int raw[2];
        dl     = m_db[0];
        dr     = m_db[1];
        dir    = 0;
        raw[0] = raw_l;
        raw[1] = raw_r;
        m_edge++;
        for (int i = 0; i < 2; i++) begin
            m_win[i].push_back(m_s[i]);
            if (m_win[i].size() > DB) void'(m_win[i].pop_front());
            if (m_win[i].size() == DB) begin
                all_diff = 1;
                for (int k = 0; k < m_win[i].size(); k++)
                    if (m_win[i][k] == m_db[i]) all_diff = 0;
                if (all_diff != 0) begin
                    m_db[i] = 1 - m_db[i];
                    m_win[i].delete();
                end
            end
            m_s[i]  = m_s1[i];
            m_s1[i] = raw[i];
        end
        case (m_mode)
            0: begin
                if (dl != 0 && dr == 0) begin
                    dir = -1; m_mode = 1; m_t0 = m_edge;
                end else if (dr != 0 && dl == 0) begin
                    dir = 1; m_mode = 2; m_t0 = m_edge;
                end else if (dl != 0 && dr != 0) begin
                    m_mode = 3;
                end
            end
            1: begin
                if (dr != 0) m_mode = 3;
                else if (dl == 0) m_mode = 0;
                else if ((m_edge - m_t0) % REP == 0) dir = -1;
            end
            2: begin
                if (dl != 0) m_mode = 3;
                else if (dr == 0) m_mode = 0;
                else if ((m_edge - m_t0) % REP == 0) dir = 1;
            end
            default: begin
                if (dl == 0 && dr == 0) m_mode = 0;
            end
        endcase
        np = m_pos + dir;
        if (np < 0) np = 0;
        if (np > COL - PWD) np = COL - PWD;
        m_moved = (np != m_pos) ? 1 : 0;
        m_pos   = np;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(int'(btn_left), int'(btn_right));
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("pos", int'(paddle_pos), m_pos);
            chk("mask", int'(down_player), exp_mask(m_pos));
            chk("moved", int'(moved), m_moved);
            chk("mask_popcount", $countones(down_player), PWD);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Asserts reset between clock edges and checks that the outputs clear before any edge.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pos", int'(paddle_pos), 1);
        chk("async_rst_mask", int'(down_player), 'b0110);
        chk("async_rst_moved", int'(moved), 0);
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        tick(3);
        chk("reset_pos", int'(paddle_pos), 1);
        chk("reset_mask", int'(down_player), 'b0110);
        chk("reset_moved", int'(moved), 0);
        chk("model_reset_pos", m_pos, 1);
        rst = 1'b0;

        // Single press of 5 cycles: the move lands on edge 7.
        btn_left = 1'b1;
        tick(5);
        btn_left = 1'b0;
        tick(1);
        chk("press_e6_pos", int'(paddle_pos), 1);
        tick(1);
        chk("press_e7_pos", int'(paddle_pos), 0);
        chk("press_e7_mask", int'(down_player), 'b0011);
        chk("press_e7_moved", int'(moved), 1);
        chk("model_e7_pos", m_pos, 0);
        tick(1);
        chk("press_e8_moved", int'(moved), 0);
        tick(20);

        // Bounce: 3 high, 1 low, 3 high never debounces.
        pulse_reset();
        btn_right = 1'b1; tick(3);
        btn_right = 1'b0; tick(1);
        btn_right = 1'b1; tick(3);
        btn_right = 1'b0; tick(20);
        chk("bounce_pos", int'(paddle_pos), 1);

        // Hold right and hit the clamp.
        pulse_reset();
        btn_right = 1'b1;
        tick(6);
        chk("hold_e6_pos", int'(paddle_pos), 1);
        tick(1);
        chk("hold_e7_pos", int'(paddle_pos), 2);
        chk("hold_e7_mask", int'(down_player), 'b1100);
        chk("hold_e7_moved", int'(moved), 1);
        tick(8);
        chk("hold_e15_pos", int'(paddle_pos), 2);
        chk("hold_e15_moved", int'(moved), 0);
        tick(25);
        btn_right = 1'b0;
        chk("hold_e40_pos", int'(paddle_pos), 2);
        tick(20);

        // Chord from idle, then release only left: the paddle must not move.
        pulse_reset();
        btn_left = 1'b1; btn_right = 1'b1;
        tick(20);
        chk("chord_pos", int'(paddle_pos), 1);
        btn_left = 1'b0;
        tick(30);
        chk("chord_release_left_pos", int'(paddle_pos), 1);
        btn_right = 1'b0;
        tick(10);
        btn_left = 1'b1;
        tick(7);
        chk("after_chord_press_pos", int'(paddle_pos), 0);
        btn_left = 1'b0;
        tick(20);

        // Left held, right added 2 cycles after the first step.
        pulse_reset();
        btn_left = 1'b1;
        tick(7);
        chk("both_first_step_pos", int'(paddle_pos), 0);
        tick(2);
        btn_right = 1'b1;
        tick(30);
        chk("both_hold_pos", int'(paddle_pos), 0);
        btn_left = 1'b0;
        tick(20);
        chk("both_release_left_pos", int'(paddle_pos), 0);
        btn_right = 1'b0;
        tick(20);

        // Reset mid-hold while the button stays down: the button must debounce again.
        pulse_reset();
        btn_right = 1'b1;
        tick(7);
        chk("midhold_pre_pos", int'(paddle_pos), 2);
        tick(3);
        pulse_reset();
        tick(6);
        chk("midhold_e6_pos", int'(paddle_pos), 1);
        tick(1);
        chk("midhold_e7_pos", int'(paddle_pos), 2);
        chk("midhold_e7_moved", int'(moved), 1);
        btn_right = 1'b0;
        tick(20);

        // Random traffic, including short glitches and occasional resets.
        for (int seg = 0; seg < 160; seg++) begin
            btn_left  = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
            else tick($urandom_range(5, 30));
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
